// File: rtl/sram_access_ctrl.sv
// Valid/ready front end for a 2**AW x DW single-port SRAM macro with an ordered read-response FIFO.
// Define SRAM_ACCESS_CTRL_INIT_EN to zero-fill the whole array after every reset.

module sram_access_ctrl_chk #(
  parameter int RSP_DEPTH = 3,
  parameter int CW        = 2
) (
  input logic          clk,
  input logic          rst,
  input logic          push,
  input logic [CW-1:0] count
);
  // A push into a full FIFO means the credit rule was broken.
  assert property (@(posedge clk) disable iff (rst) !(push && (count == CW'(RSP_DEPTH))));
endmodule

module sram_access_ctrl #(
  parameter int AW        = 7,
  parameter int DW        = 16,
  parameter int RSP_DEPTH = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_rdata,
  output logic          init_done,
  output logic          mem_cen,
  output logic          mem_wen,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_din,
  input  logic [DW-1:0] mem_dout
);
  localparam int PW = $clog2(RSP_DEPTH);
  localparam int CW = $clog2(RSP_DEPTH + 1);

  logic          run_s;
  logic          sweep_s;
  logic [AW-1:0] sweep_addr_s;
  logic          accept_s;
  logic          push_s;
  logic          pop_s;
  logic [CW:0]   outstanding_s;
  logic          inflight_r;
  logic [DW-1:0] fifo_r [RSP_DEPTH];
  logic [PW-1:0] wr_ptr_r;
  logic [PW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;
  logic [AW-1:0] last_addr_r;
  logic [DW-1:0] last_din_r;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(RSP_DEPTH - 1)) begin
      return '0;
    end else begin
      return p + PW'(1'b1);
    end
  endfunction

`ifdef SRAM_ACCESS_CTRL_INIT_EN
  typedef enum logic [0:0] {INIT = 1'b0, RUN = 1'b1} state_t;
  state_t        state_r;
  state_t        state_nxt_s;
  logic [AW-1:0] cnt_r;
  logic [AW-1:0] cnt_nxt_s;

  // State and sweep-counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= INIT;
      cnt_r   <= '0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

  // Walk every address once; the counter saturates on the last word and hands over to RUN.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    sweep_s     = 1'b0;
    run_s       = 1'b0;
    case (state_r)
      INIT: begin
        sweep_s = ~rst;
        if (cnt_r == {AW{1'b1}}) begin
          state_nxt_s = RUN;
        end else begin
          cnt_nxt_s = cnt_r + AW'(1'b1);
        end
      end
      RUN: begin
        run_s = 1'b1;
      end
      default: begin
        state_nxt_s = INIT;
      end
    endcase
  end

  assign sweep_addr_s = cnt_r;
`else
  assign run_s        = 1'b1;
  assign sweep_s      = 1'b0;
  assign sweep_addr_s = '0;
`endif

  // Every accepted read holds a FIFO slot from acceptance until it is popped.
  assign outstanding_s = {1'b0, count_r} + {{CW{1'b0}}, inflight_r};
  assign req_ready     = ~rst & run_s & (outstanding_s < (CW+1)'(RSP_DEPTH));
  assign accept_s      = req_valid & req_ready;
  assign init_done     = ~rst & run_s;

  // Macro pins follow the accepted request in the same cycle; address and data hold otherwise.
  always_comb begin
    mem_cen  = 1'b1;
    mem_wen  = 1'b1;
    mem_addr = last_addr_r;
    mem_din  = last_din_r;
    if (rst) begin
      mem_addr = '0;
      mem_din  = '0;
    end else if (sweep_s) begin
      mem_cen  = 1'b0;
      mem_wen  = 1'b0;
      mem_addr = sweep_addr_s;
      mem_din  = '0;
    end else if (accept_s) begin
      mem_cen  = 1'b0;
      mem_wen  = ~req_we;
      mem_addr = req_addr;
      mem_din  = req_wdata;
    end else begin
      mem_cen  = 1'b1;
      mem_wen  = 1'b1;
    end
  end

  // Remember the last value driven onto the macro address and data pins.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_addr_r <= '0;
      last_din_r  <= '0;
    end else if (!mem_cen) begin
      last_addr_r <= mem_addr;
      last_din_r  <= mem_din;
    end
  end

  // A read sampled by the macro returns data one cycle later.
  always_ff @(posedge clk) begin
    if (rst) begin
      inflight_r <= 1'b0;
    end else begin
      inflight_r <= accept_s & ~req_we;
    end
  end

  assign push_s = inflight_r;
  assign pop_s  = (count_r != '0) & rsp_ready;

  // Response FIFO storage, pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
      for (int i = 0; i < RSP_DEPTH; i++) begin
        fifo_r[i] <= '0;
      end
    end else begin
      if (push_s) begin
        fifo_r[wr_ptr_r] <= mem_dout;
        wr_ptr_r         <= ptr_inc(wr_ptr_r);
      end
      if (pop_s) begin
        rd_ptr_r <= ptr_inc(rd_ptr_r);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CW'(1'b1);
        2'b01:   count_r <= count_r - CW'(1'b1);
        default: count_r <= count_r;
      endcase
    end
  end

  assign rsp_valid = (count_r != '0);
  assign rsp_rdata = fifo_r[rd_ptr_r];

  sram_access_ctrl_chk #(
    .RSP_DEPTH(RSP_DEPTH),
    .CW       (CW)
  ) u_chk (
    .clk  (clk),
    .rst  (rst),
    .push (push_s),
    .count(count_r)
  );
endmodule
